// File: rtl/ri_pkg.sv
// Shared types and helpers for the ring_stepper position generator.
package ri_pkg;

  localparam int unsigned N_POS = 26;
  localparam int unsigned POS_W = 5;

  typedef logic [N_POS-1:0] onehot_t;
  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // True when idx names a real position (1..N_POS).
  function automatic logic idx_valid(input pos_t idx);
    return (idx != '0) && (idx <= pos_t'(N_POS));
  endfunction

  // One-hot word for a valid position index; bit k stands for position k+1.
  function automatic onehot_t idx_to_onehot(input pos_t idx);
    return onehot_t'(1) << (idx - pos_t'(1));
  endfunction

endpackage

// File: rtl/key_edge.sv
// Step-key conditioner: optional 2-flop synchronizer plus rising-edge detector.
// Build macro RI_KEY_SYNC_EN inserts the synchronizer for asynchronous keys.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

`ifdef RI_KEY_SYNC_EN
  logic       meta;
  logic       sync;
  logic [1:0] fill;
  logic       armed;

  // Synchronize the key; arm only once the chain holds a real sample and the
  // key was seen low, so a key held through reset never fires on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      meta  <= key;
      sync  <= meta;
      fill  <= {fill[0], 1'b1};
      armed <= fill[1] & ~sync;
    end
  end

  assign pulse = sync & armed;
`else
  logic armed;

  // armed holds "key was low last cycle"; cleared by reset so a held key
  // must be released before it can pulse again.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else begin
      armed <= ~key;
    end
  end

  assign pulse = key & armed;
`endif

endmodule

// File: rtl/ring_stepper.sv
// One-hot 26-position ring stepper feeding hexdriver.val.
// Steps on prescaler tick or step-key press, up or down, with direct load.
// Build macro RI_KEY_SYNC_EN adds a key synchronizer (see key_edge).
module ring_stepper
  import ri_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    run,
  input  logic    dir,
  input  logic    step_key,
  input  logic    load,
  input  pos_t    load_idx,
  output onehot_t val,
  output pos_t    pos,
  output logic    wrap,
  output logic    load_err
);

  localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic          key_pulse;
  dir_e          step_dir;

  assign tick     = run && (cnt == CNT_LAST);
  assign step_dir = dir_e'(dir);

  key_edge u_key_edge (
    .clk   (clk),
    .reset (reset),
    .key   (step_key),
    .pulse (key_pulse)
  );

  // Prescaler and position register; load beats key beats tick, and any
  // losing event in a cycle is dropped rather than queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      val      <= onehot_t'(1);
      pos      <= pos_t'(1);
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (idx_valid(load_idx)) begin
          val <= idx_to_onehot(load_idx);
          pos <= load_idx;
          cnt <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        if (run) begin
          cnt <= tick ? '0 : cnt + CW'(1);
        end
        if (key_pulse || tick) begin
          if (step_dir == DIR_UP) begin
            val <= {val[N_POS-2:0], val[N_POS-1]};
            if (pos == pos_t'(N_POS)) begin
              pos  <= pos_t'(1);
              wrap <= 1'b1;
            end else begin
              pos <= pos + pos_t'(1);
            end
          end else begin
            val <= {val[0], val[N_POS-1:1]};
            if (pos == pos_t'(1)) begin
              pos  <= pos_t'(N_POS);
              wrap <= 1'b1;
            end else begin
              pos <= pos - pos_t'(1);
            end
          end
        end
      end
    end
  end

endmodule
